// File: rtl/ls_wb_reg.sv
`default_nettype none
// ============================================================================
// Module  : ls_wb_reg
// Brief   : LS->WB pipeline register: load alignment/extension, RF write port,
//           halt-monitor outputs and ebreak freeze.
// Revision: 1.0
// ============================================================================
module ls_wb_reg #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic [DATA_LEN-1:0] ls_pc,
    input  logic [4:0]          ls_rd,
    input  logic                ls_rd_wen,
    input  logic                ls_is_load,
    input  logic [1:0]          ls_load_size,
    input  logic                ls_load_unsigned,
    input  logic [1:0]          ls_addr_low,
    input  logic [DATA_LEN-1:0] ls_load_rdata,
    input  logic [DATA_LEN-1:0] ls_alu_result,
    input  logic                ls_ebreak,
    output logic                LS_WB_reg_ls_valid,
    output logic                LS_WB_reg_ebreak,
    output logic [DATA_LEN-1:0] LS_WB_reg_pc,
    output logic                wb_wen,
    output logic [4:0]          wb_rd,
    output logic [DATA_LEN-1:0] wb_wdata,
    output logic                wb_misalign,
    output logic [63:0]         inst_retired
);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_accept;
    logic [4:0]          w_shamt;
    logic [DATA_LEN-1:0] w_shifted;
    logic                w_sign_b;
    logic                w_sign_h;
    logic [DATA_LEN-1:0] w_load_data;
    logic [DATA_LEN-1:0] w_wdata;
    logic                w_misalign;

    logic                r_valid;
    logic                r_ebreak;
    logic [DATA_LEN-1:0] r_pc;
    logic [4:0]          r_rd;
    logic                r_rd_wen;
    logic [DATA_LEN-1:0] r_wdata;
    logic                r_misalign;
    logic [63:0]         r_inst_retired;

    assign w_accept = ls_valid & ls_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: only an accepted ebreak halts; only reset leaves HALT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:  if (w_accept && ls_ebreak) w_state_next = c_ST_HALT;
            c_ST_HALT: w_state_next = c_ST_HALT;
            default:   w_state_next = c_ST_RUN;
        endcase
    end

    // Outputs: ready depends on state alone
    always_comb begin
        ls_ready = (r_state == c_ST_RUN);
    end

    assign w_shamt   = {ls_addr_low, 3'b000};
    assign w_shifted = ls_load_rdata >> w_shamt;
    assign w_sign_b  = ~ls_load_unsigned & w_shifted[7];
    assign w_sign_h  = ~ls_load_unsigned & w_shifted[15];

    always_comb begin
        w_load_data = w_shifted;
        case (ls_load_size)
            2'b00:   w_load_data = {{(DATA_LEN-8){w_sign_b}},  w_shifted[7:0]};
            2'b01:   w_load_data = {{(DATA_LEN-16){w_sign_h}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    assign w_wdata    = ls_is_load ? w_load_data : ls_alu_result;
    assign w_misalign = ls_is_load &
                        (((ls_load_size == 2'b01) & ls_addr_low[0]) |
                         ((ls_load_size == 2'b10) & (ls_addr_low != 2'b00)) |
                          (ls_load_size == 2'b11));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= 1'b0;
            r_ebreak       <= 1'b0;
            r_pc           <= '0;
            r_rd           <= '0;
            r_rd_wen       <= 1'b0;
            r_wdata        <= '0;
            r_misalign     <= 1'b0;
            r_inst_retired <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_ebreak       <= ls_ebreak;
                r_pc           <= ls_pc;
                r_rd           <= ls_rd;
                r_rd_wen       <= ls_rd_wen;
                r_wdata        <= w_wdata;
                r_misalign     <= w_misalign;
                // Counting at accept makes the count visible alongside valid
                r_inst_retired <= r_inst_retired + 64'd1;
            end
        end
    end

    assign LS_WB_reg_ls_valid = r_valid;
    assign LS_WB_reg_ebreak   = r_ebreak;
    assign LS_WB_reg_pc       = r_pc;
    assign wb_rd              = r_rd;
    assign wb_wdata           = r_wdata;
    assign wb_misalign        = r_misalign;
    assign wb_wen             = r_valid & r_rd_wen & (r_rd != 5'd0) & ~r_misalign;
    assign inst_retired       = r_inst_retired;

endmodule
`default_nettype wire

// File: doc/ls_wb_reg.md
# ls_wb_reg

Pipeline register and writeback stage between the load/store (LS) stage and the register file / simulation monitor. It accepts one retiring instruction per cycle from LS through a valid/ready handshake. Load data is aligned and sign/zero-extended before it is registered, and the block drives the register-file write port. It also produces the `LS_WB_reg_ls_valid` / `LS_WB_reg_ebreak` pair consumed by the halt monitor, and freezes the pipeline once an `ebreak` retires.

## Interface
- `DATA_LEN`, 32, datapath width (bits).
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ls_valid`  in  1  LS stage presents an instruction.
- `ls_ready`  out  1  block can accept this cycle.
- `ls_pc`  in  DATA_LEN  PC of presented instruction.
- `ls_rd`  in  5  destination register index.
- `ls_rd_wen`  in  1  instruction writes rd.
- `ls_is_load`  in  1  result comes from memory, not ALU.
- `ls_load_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal and is treated as misaligned.
- `ls_load_unsigned`  in  1  zero-extend (LBU/LHU).
- `ls_addr_low`  in  2  load address bits [1:0].
- `ls_load_rdata`  in  DATA_LEN  raw aligned word read from memory.
- `ls_alu_result`  in  DATA_LEN  non-load result.
- `ls_ebreak`  in  1  instruction is `ebreak`.
- `LS_WB_reg_ls_valid`  out  1  registered instruction valid this cycle.
- `LS_WB_reg_ebreak`  out  1  registered instruction is `ebreak`.
- `LS_WB_reg_pc`  out  DATA_LEN  registered PC.
- `wb_wen`  out  1  register-file write enable.
- `wb_rd`  out  5  register-file write index.
- `wb_wdata`  out  DATA_LEN  register-file write data.
- `wb_misalign`  out  1  registered instruction was a misaligned load.
- `inst_retired`  out  64  count of retired instructions.

## Operation
- **States:**
  - RUN: `ls_ready` is 1.
  - HALT: `ls_ready` is 0.
- **Transitions:**
  - RUN→HALT on the cycle an instruction with `ls_ebreak=1` is accepted.
  - HALT is left only by reset.
- **Accept:** a transfer happens when `ls_valid & ls_ready`. All `LS_WB_reg_*` and `wb_*` fields load from the LS inputs. `LS_WB_reg_ls_valid` is set to 1.
- **No transfer:** `LS_WB_reg_ls_valid` is cleared to 0. Data registers hold their values.
- **Load alignment:** the shift amount is 8·`ls_addr_low`. The word is `ls_load_rdata >> shift`.
  - Byte: bits [7:0].
  - Half: bits [15:0].
  - Word: all bits.
  - Extension: sign-extend from the top bit of the selected field unless `ls_load_unsigned`, in which case zero-extend.
- **Non-load:** `wb_wdata` ← `ls_alu_result`. The size, unsigned and address-low inputs are ignored.
- **Misalign:** `ls_is_load` and any of the following: half with `addr_low[0]=1`, word with `addr_low≠0`, or size 11. The registered `wb_misalign` is set to 1, no register write occurs, and `inst_retired` still increments.
- **`wb_wen`** = `LS_WB_reg_ls_valid` & registered `rd_wen` & (registered rd ≠ 0) & ~`wb_misalign`. This is combinational from registered state.
- **`inst_retired`** increments by 1 on every cycle in which `LS_WB_reg_ls_valid=1`. It wraps modulo 2^64.

## Timing
- **Reset:** all outputs 0 except `ls_ready`, which is 1. State is RUN and `inst_retired` is 0.
- **Latency:** 1 cycle. Inputs accepted at edge N appear on outputs during cycle N+1.
- **Throughput:** back-to-back accepts give `LS_WB_reg_ls_valid` high on consecutive cycles.
- **Handshake:** `ls_ready` depends only on state, never on `ls_valid`.
  - In HALT, `ls_valid` is ignored: no capture, no counter change.
  - LS must hold its inputs stable while `ls_valid & ~ls_ready`.
- **Ebreak cycle:** the `ebreak` instruction is accepted at edge N.
  - Cycle N+1: `LS_WB_reg_ls_valid=1`, `LS_WB_reg_ebreak=1` (the monitor halts here), and `ls_ready=0`.
  - Cycle N+2 onward: `LS_WB_reg_ls_valid=0`.
- **`LS_WB_reg_ebreak`:** its value is defined only while `LS_WB_reg_ls_valid=1`. Consumers must qualify it with valid.
- **Reset mid-operation:** asserting `rst_n` low clears state immediately (asynchronous), including from HALT. The first accept can occur at the first rising edge after deassertion.

## Test plan
- **Word load:** `ls_load_rdata=0x80FF1234`, word, addr_low 0, rd=5 → next cycle `wb_wen=1`, `wb_rd=5`, `wb_wdata=0x80FF1234`, `inst_retired=1`.
- **Sign/zero extension** on `ls_load_rdata=0x80FF1234`:
  - Signed byte, addr_low 3 → `wb_wdata=0xFFFFFF80`.
  - Unsigned half, addr_low 2 → `0x000080FF`.
  - Signed byte, addr_low 1 → `0x00000012`.
- **Back-to-back ALU ops:** 4 ALU ops on consecutive cycles, results 1..4, the third with rd=0 → `LS_WB_reg_ls_valid` high 4 consecutive cycles, `wb_wen` pattern 1,1,0,1, `inst_retired=4`.
- **Misaligned loads:** half load at addr_low 1, then word load at addr_low 2 → `wb_misalign=1` and `wb_wen=0` on both cycles, counter +2.
- **Ebreak:** `ebreak` accepted, `ls_valid` then held high with further ALU ops → one cycle with `LS_WB_reg_ls_valid=1` and `LS_WB_reg_ebreak=1`, then `ls_ready=0`, `LS_WB_reg_ls_valid=0`, and `inst_retired` frozen.
- **Reset from HALT:** `rst_n` pulsed low while in HALT → outputs go to their reset values asynchronously, `ls_ready=1`, and the next ALU op is retired normally.
